match_controller: RTL

MATCH_CONTROLLER -- requirements
Module: match_controller

---
 rtl/match_pkg.sv | 18 +
 rtl/fighter_health.sv | 49 ++++
 rtl/match_controller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - match controller state encoding and shared field widths
package match_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COUNTDOWN  = 3'd1,
        ST_FIGHT      = 3'd2,
        ST_ROUND_END  = 3'd3,
        ST_MATCH_OVER = 3'd4
    } match_state_t;

    localparam int ROUND_NUM_W   = 3;
    localparam int WINS_W        = 2;
    localparam int ROUND_TIMER_W = 13;
    localparam int FRAME_CNT_W   = 16;
    localparam int MAX_ROUND     = 7;

endpackage

// File: rtl/fighter_health.sv
// rtl/fighter_health.sv - one fighter's health register with saturating damage
module fighter_health #(
    parameter int HEALTH_W   = 8,
    parameter int MAX_HEALTH = 100,
    parameter int HIT_DMG    = 10,
    parameter int BLOCK_DMG  = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                restore,
    input  logic                enable,
    input  logic                hit,
    input  logic                block,
    output logic [HEALTH_W-1:0] health,
    output logic                death,
    output logic [HEALTH_W-1:0] health_next
);

    logic [HEALTH_W-1:0] health_q, health_d;
    logic                death_q, death_d;
    logic [HEALTH_W-1:0] dmg;

    always_comb begin
        dmg      = block ? HEALTH_W'(BLOCK_DMG) : HEALTH_W'(HIT_DMG);
        health_d = health_q;
        if (restore) begin
            health_d = HEALTH_W'(MAX_HEALTH);
        end else if (enable && hit) begin
            health_d = (health_q > dmg) ? health_q - dmg : '0;
        end
        death_d = (health_d == '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            health_q <= HEALTH_W'(MAX_HEALTH);
            death_q  <= 1'b0;
        end else begin
            health_q <= health_d;
            death_q  <= death_d;
        end
    end

    assign health      = health_q;
    assign death       = death_q;
    // The top needs post-update health to end a round on the same edge as the KO.
    assign health_next = health_d;

endmodule

// File: rtl/match_controller.sv
// rtl/match_controller.sv - fighting-game match FSM; MATCH_TIMER_EN enables round timeout
module match_controller
    import match_pkg::*;
#(
    parameter int NUM_PLAYERS      = 2,
    parameter int HEALTH_W         = 8,
    parameter int MAX_HEALTH       = 100,
    parameter int HIT_DMG          = 10,
    parameter int BLOCK_DMG        = 2,
    parameter int ROUNDS_TO_WIN    = 2,
    parameter int COUNTDOWN_FRAMES = 120,
    parameter int ROUND_FRAMES     = 5400,
    parameter int HOLD_FRAMES      = 180
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            start,
    input  logic [NUM_PLAYERS-1:0]          hit,
    input  logic [NUM_PLAYERS-1:0]          block,
    output logic [NUM_PLAYERS*HEALTH_W-1:0] health,
    output logic [NUM_PLAYERS-1:0]          death,
    output logic                            game_playing,
    output logic [2:0]                      state,
    output logic [ROUND_NUM_W-1:0]          round_num,
    output logic [NUM_PLAYERS*WINS_W-1:0]   wins,
    output logic [ROUND_TIMER_W-1:0]        round_timer,
    output logic [1:0]                      winner,
    output logic                            winner_valid
);

    if (ROUND_FRAMES < 2 || ROUND_FRAMES >= (1 << ROUND_TIMER_W)) begin : g_bad_round_frames
        $error("ROUND_FRAMES out of range for round_timer");
    end

    match_state_t                  state_q, state_d;
    logic [FRAME_CNT_W-1:0]        cnt_q, cnt_d;
    logic [ROUND_NUM_W-1:0]        round_num_q, round_num_d;
    logic [NUM_PLAYERS*WINS_W-1:0] wins_q, wins_d;
    logic [1:0]                    winner_q, winner_d;
    logic                          winner_valid_q, winner_valid_d;
    logic                          game_playing_q, game_playing_d;
`ifdef MATCH_TIMER_EN
    logic [ROUND_TIMER_W-1:0]      timer_q, timer_d;
`endif

    logic                          restore;
    logic                          fight_en;
    logic [HEALTH_W-1:0]           hn [NUM_PLAYERS];

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_fighter
        fighter_health #(
            .HEALTH_W   (HEALTH_W),
            .MAX_HEALTH (MAX_HEALTH),
            .HIT_DMG    (HIT_DMG),
            .BLOCK_DMG  (BLOCK_DMG)
        ) u_fighter (
            .Clk         (Clk),
            .Reset       (Reset),
            .restore     (restore),
            .enable      (fight_en),
            .hit         (hit[g]),
            .block       (block[g]),
            .health      (health[g*HEALTH_W +: HEALTH_W]),
            .death       (death[g]),
            .health_next (hn[g])
        );
    end

    assign fight_en = (state_q == ST_FIGHT);

    logic [2:0]          alive_cnt;
    logic [1:0]          alive_idx;
    logic [HEALTH_W-1:0] max_h;
    logic [1:0]          max_idx;
    logic                max_tie;
    logic                win_inc;
    logic [1:0]          win_idx;
    logic                champ_found;
    logic [1:0]          champ_idx;

    // Survivor and leader scan over post-update health.
    always_comb begin
        alive_cnt   = '0;
        alive_idx   = '0;
        max_h       = '0;
        max_idx     = '0;
        max_tie     = 1'b0;
        champ_found = 1'b0;
        champ_idx   = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (hn[i] != '0) begin
                alive_cnt = alive_cnt + 3'd1;
                alive_idx = 2'(i);
            end
            if (hn[i] > max_h) begin
                max_h   = hn[i];
                max_idx = 2'(i);
                max_tie = 1'b0;
            end else if (hn[i] == max_h) begin
                max_tie = 1'b1;
            end
            if (!champ_found && wins_q[i*WINS_W +: WINS_W] == WINS_W'(ROUNDS_TO_WIN)) begin
                champ_found = 1'b1;
                champ_idx   = 2'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        round_num_d    = round_num_q;
        wins_d         = wins_q;
        winner_d       = winner_q;
        winner_valid_d = winner_valid_q;
        restore        = 1'b0;
        win_inc        = 1'b0;
        win_idx        = '0;
`ifdef MATCH_TIMER_EN
        timer_d        = timer_q;
`endif
        case (state_q)
            ST_IDLE, ST_MATCH_OVER: begin
                if (start) begin
                    state_d        = ST_COUNTDOWN;
                    cnt_d          = '0;
                    round_num_d    = ROUND_NUM_W'(1);
                    wins_d         = '0;
                    winner_d       = '0;
                    winner_valid_d = 1'b0;
                    restore        = 1'b1;
`ifdef MATCH_TIMER_EN
                    timer_d        = '0;
`endif
                end
            end
            ST_COUNTDOWN: begin
                if (cnt_q == FRAME_CNT_W'(COUNTDOWN_FRAMES - 1)) begin
                    state_d = ST_FIGHT;
                    cnt_d   = '0;
`ifdef MATCH_TIMER_EN
                    timer_d = ROUND_TIMER_W'(ROUND_FRAMES);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIGHT: begin
`ifdef MATCH_TIMER_EN
                if (timer_q != '0) timer_d = timer_q - 1'b1;
`endif
                if (alive_cnt <= 3'd1) begin
                    state_d        = ST_ROUND_END;
                    cnt_d          = '0;
                    winner_d       = (alive_cnt == 3'd1) ? alive_idx : 2'd0;
                    winner_valid_d = (alive_cnt == 3'd1);
                    win_inc        = (alive_cnt == 3'd1);
                    win_idx        = alive_idx;
                end
`ifdef MATCH_TIMER_EN
                else if (timer_q == ROUND_TIMER_W'(1)) begin
                    state_d        = ST_ROUND_END;
                    cnt_d          = '0;
                    winner_d       = max_tie ? 2'd0 : max_idx;
                    winner_valid_d = !max_tie;
                    win_inc        = !max_tie;
                    win_idx        = max_idx;
                end
`endif
            end
            ST_ROUND_END: begin
                if (cnt_q == FRAME_CNT_W'(HOLD_FRAMES - 1)) begin
                    cnt_d = '0;
                    if (champ_found) begin
                        state_d        = ST_MATCH_OVER;
                        winner_d       = champ_idx;
                        winner_valid_d = 1'b1;
                    end else begin
                        state_d        = ST_COUNTDOWN;
                        restore        = 1'b1;
                        winner_valid_d = 1'b0;
                        if (round_num_q != ROUND_NUM_W'(MAX_ROUND))
                            round_num_d = round_num_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (win_inc && win_idx == 2'(i))
                wins_d[i*WINS_W +: WINS_W] = wins_q[i*WINS_W +: WINS_W] + 1'b1;
        end
        game_playing_d = (state_d == ST_FIGHT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            round_num_q    <= '0;
            wins_q         <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            game_playing_q <= 1'b0;
`ifdef MATCH_TIMER_EN
            timer_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            round_num_q    <= round_num_d;
            wins_q         <= wins_d;
            winner_q       <= winner_d;
            winner_valid_q <= winner_valid_d;
            game_playing_q <= game_playing_d;
`ifdef MATCH_TIMER_EN
            timer_q        <= timer_d;
`endif
        end
    end

    assign state        = state_q;
    assign round_num    = round_num_q;
    assign wins         = wins_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;
    assign game_playing = game_playing_q;
`ifdef MATCH_TIMER_EN
    assign round_timer  = timer_q;
`else
    assign round_timer  = '0;
`endif

endmodule
